// File: rtl/gate_lab_pkg.sv
// Shared types and constants for the gate lab stimulus/check sequencers.
// Covers the truth-table sweep state machine and the vector indexing.
package gate_lab_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } stim_state_t;

  localparam int NUM_VECTORS = 4;
  localparam int VEC_W       = 2;

  // True on the final truth-table vector (b,a = 1,1).
  function automatic logic is_last_vec(input logic [VEC_W-1:0] idx);
    return (idx == VEC_W'(NUM_VECTORS - 1));
  endfunction

endpackage

// File: rtl/gate_stim_checker_hold_timer.sv
// Down-counter with reload: zero is high once the count has run out.
// Shared by the lab sequencers to pace how long each stimulus is held.
module hold_timer #(
  parameter int WIDTH = 4,
  parameter int LOAD  = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic tick,
  output logic zero
);

  logic [WIDTH-1:0] cnt_r;

  // Load takes priority over counting; the count parks at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= WIDTH'(LOAD);
    end else if (tick && (cnt_r != '0)) begin
      cnt_r <= cnt_r - WIDTH'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == '0);

endmodule

// File: rtl/gate_stim_checker.sv
// Self-timed truth-table sweep for a 2-input gate under test: drives a/b,
// samples the gate outputs at the end of each hold window and scores them.
module gate_stim_checker
  import gate_lab_pkg::*;
#(
  parameter int                    HOLD_CYCLES = 10,
  parameter int                    NUM_OUT     = 3,
  parameter logic [4*NUM_OUT-1:0]  EXPECTED    = 12'h7B0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   a,
  output logic                   b,
  input  logic [NUM_OUT-1:0]     y,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [1:0]             vec_idx,
  output logic [4*NUM_OUT-1:0]   result,
  output logic [2:0]             mismatch_cnt
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  if (HOLD_CYCLES < 2) begin : g_bad_hold
    $error("gate_stim_checker: HOLD_CYCLES must be >= 2");
  end

  stim_state_t           state_r;
  logic [VEC_W-1:0]      vec_idx_r;
  logic                  a_r;
  logic                  b_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  pass_r;
  logic [4*NUM_OUT-1:0]  result_r;
  logic [2:0]            mis_cnt_r;

  logic                  accept_s;
  logic                  tick_s;
  logic                  load_s;
  logic                  zero_s;
  logic                  mismatch_s;
  logic [NUM_OUT-1:0]    exp_slice_s;
  logic [VEC_W-1:0]      next_idx_s;

  // Start is honoured only when no sweep is running; the timer reloads per vector.
  always_comb begin
    accept_s    = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    tick_s      = (state_r == ST_DRIVE);
    load_s      = accept_s || (tick_s && zero_s && !is_last_vec(vec_idx_r));
    exp_slice_s = EXPECTED[int'(vec_idx_r)*NUM_OUT +: NUM_OUT];
    mismatch_s  = (y != exp_slice_s);
    next_idx_s  = vec_idx_r + VEC_W'(1);
  end

  hold_timer #(
    .WIDTH (CNT_W),
    .LOAD  (HOLD_CYCLES - 1)
  ) u_hold_timer (
    .clk  (clk),
    .rst  (rst),
    .load (load_s),
    .tick (tick_s),
    .zero (zero_s)
  );

  // Sweep FSM: a/b move together with vec_idx so the DUT never sees skew.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      vec_idx_r <= '0;
      a_r       <= 1'b0;
      b_r       <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
      result_r  <= '0;
      mis_cnt_r <= 3'd0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            state_r   <= ST_DRIVE;
            vec_idx_r <= '0;
            a_r       <= 1'b0;
            b_r       <= 1'b0;
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            result_r  <= '0;
            mis_cnt_r <= 3'd0;
          end
        end
        ST_DRIVE: begin
          if (zero_s) begin
            result_r[int'(vec_idx_r)*NUM_OUT +: NUM_OUT] <= y;
            mis_cnt_r <= mis_cnt_r + {2'b00, mismatch_s};
            if (is_last_vec(vec_idx_r)) begin
              // Verdict folds in the final vector sampled on this same edge.
              state_r <= ST_DONE;
              a_r     <= 1'b0;
              b_r     <= 1'b0;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              pass_r  <= (mis_cnt_r == 3'd0) && !mismatch_s;
            end else begin
              vec_idx_r <= next_idx_s;
              a_r       <= next_idx_s[0];
              b_r       <= next_idx_s[1];
            end
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          vec_idx_r <= '0;
          a_r       <= 1'b0;
          b_r       <= 1'b0;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
          pass_r    <= 1'b0;
          result_r  <= '0;
          mis_cnt_r <= 3'd0;
        end
      endcase
    end
  end

  assign a            = a_r;
  assign b            = b_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign pass         = pass_r;
  assign vec_idx      = vec_idx_r;
  assign result       = result_r;
  assign mismatch_cnt = mis_cnt_r;

endmodule

// File: tb/tb_gate_stim_checker.sv
// Bench for gate_stim_checker: AND/OR/XOR gate model with injectable faults,
// a truth-table reference model, and a second instance with HOLD_CYCLES=2.
module tb_gate_stim_checker;

  logic        clk;
  logic        rst;
  logic        start;
  logic        a, b, busy, done, pass;
  logic [1:0]  vec_idx;
  logic [11:0] result;
  logic [2:0]  mismatch_cnt;
  logic [2:0]  y;

  logic        start_h;
  logic        a_h, b_h, busy_h, done_h, pass_h;
  logic [1:0]  vec_idx_h;
  logic [11:0] result_h;
  logic [2:0]  mismatch_cnt_h;
  logic [2:0]  y_h;

  logic [2:0]  fault_tbl [4];
  int          n_cmp;
  int          n_bad;

  gate_stim_checker #(.HOLD_CYCLES(10), .NUM_OUT(3), .EXPECTED(12'h7B0)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .y(y),
    .busy(busy), .done(done), .pass(pass), .vec_idx(vec_idx),
    .result(result), .mismatch_cnt(mismatch_cnt)
  );

  gate_stim_checker #(.HOLD_CYCLES(2), .NUM_OUT(3), .EXPECTED(12'h7B0)) dut_h (
    .clk(clk), .rst(rst), .start(start_h), .a(a_h), .b(b_h), .y(y_h),
    .busy(busy_h), .done(done_h), .pass(pass_h), .vec_idx(vec_idx_h),
    .result(result_h), .mismatch_cnt(mismatch_cnt_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference gate: {xor, or, and} of (a, b); k = {b, a}.
  function automatic logic [2:0] gold_y(input logic [1:0] k);
    logic av, bv;
    av = k[0];
    bv = k[1];
    return {av ^ bv, av | bv, av & bv};
  endfunction

  always_comb y = gold_y({b, a}) ^ fault_tbl[{b, a}];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start_h = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_cmp++;
    if ({a, b, busy, done, pass, vec_idx, result, mismatch_cnt} !== 22'd0) begin
      n_bad++;
      $display("FAIL reset_main: got a=%b b=%b busy=%b done=%b pass=%b idx=%0d res=%h mis=%0d required all zero",
               a, b, busy, done, pass, vec_idx, result, mismatch_cnt);
    end
    n_cmp++;
    if ({a_h, b_h, busy_h, done_h, pass_h, vec_idx_h, result_h, mismatch_cnt_h} !== 22'd0) begin
      n_bad++;
      $display("FAIL reset_short: got busy=%b done=%b res=%h mis=%0d required all zero",
               busy_h, done_h, result_h, mismatch_cnt_h);
    end
  endtask

  // One full HOLD_CYCLES=10 sweep; pulse_at >= 0 re-asserts start on edge E0+pulse_at.
  task automatic run_sweep(input string tag, input int pulse_at);
    logic [11:0] exp_res;
    int          exp_mis;
    logic [2:0]  s;
    logic [1:0]  ei;
    exp_res = 12'h000;
    exp_mis = 0;
    for (int k = 0; k < 4; k++) begin
      s = gold_y(2'(k)) ^ fault_tbl[k];
      exp_res[k*3 +: 3] = s;
      if (s != gold_y(2'(k))) exp_mis++;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (result !== 12'h000 || mismatch_cnt !== 3'd0) begin
      n_bad++;
      $display("FAIL %s_clear: got res=%h mis=%0d required 000 0", tag, result, mismatch_cnt);
    end
    for (int t = 0; t < 40; t++) begin
      ei = 2'(t / 10);
      n_cmp++;
      if ({busy, done, vec_idx, a, b} !== {1'b1, 1'b0, ei, ei[0], ei[1]}) begin
        n_bad++;
        $display("FAIL %s_drive t=%0d: got busy/done/idx/a/b=%b required %b", tag, t,
                 {busy, done, vec_idx, a, b}, {1'b1, 1'b0, ei, ei[0], ei[1]});
      end
      start = (t + 1 == pulse_at) ? 1'b1 : 1'b0;
      tick();
    end
    start = 1'b0;
    n_cmp++;
    if ({busy, done, a, b} !== 4'b0100) begin
      n_bad++;
      $display("FAIL %s_done: got busy/done/a/b=%b required 0100", tag, {busy, done, a, b});
    end
    n_cmp++;
    if (result !== exp_res || mismatch_cnt !== 3'(exp_mis) || pass !== (exp_mis == 0)) begin
      n_bad++;
      $display("FAIL %s_score: got res=%h mis=%0d pass=%b required res=%h mis=%0d pass=%b",
               tag, result, mismatch_cnt, pass, exp_res, exp_mis, (exp_mis == 0));
    end
  endtask

  task automatic test_clean_sweep();
    for (int k = 0; k < 4; k++) fault_tbl[k] = 3'b000;
    run_sweep("clean", -1);
    n_cmp++;
    if (result !== 12'h7B0 || pass !== 1'b1) begin
      n_bad++;
      $display("FAIL clean_literal: got res=%h pass=%b required 7b0 1", result, pass);
    end
  endtask

  task automatic test_xnor();
    for (int k = 0; k < 4; k++) fault_tbl[k] = 3'b100;
    run_sweep("xnor", -1);
    n_cmp++;
    if (result !== 12'hE94 || mismatch_cnt !== 3'd4 || pass !== 1'b0) begin
      n_bad++;
      $display("FAIL xnor_literal: got res=%h mis=%0d pass=%b required e94 4 0",
               result, mismatch_cnt, pass);
    end
  endtask

  task automatic test_random_faults();
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++)
        fault_tbl[k] = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'b000;
      run_sweep("random", -1);
    end
  endtask

  task automatic test_start_ignored();
    for (int k = 0; k < 4; k++) fault_tbl[k] = 3'b000;
    run_sweep("ignored", 15);
  endtask

  task automatic test_rst_mid();
    logic seen_done;
    fault_tbl[0] = 3'b001;
    for (int k = 1; k < 4; k++) fault_tbl[k] = 3'b000;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 24; t++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({a, b, busy, done, pass, vec_idx, result, mismatch_cnt} !== 22'd0) begin
      n_bad++;
      $display("FAIL rst_mid: got a=%b b=%b busy=%b done=%b idx=%0d res=%h mis=%0d required all zero",
               a, b, busy, done, vec_idx, result, mismatch_cnt);
    end
    seen_done = 1'b0;
    for (int t = 0; t < 60; t++) begin
      if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
      tick();
    end
    n_cmp++;
    if (seen_done !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_no_done: got activity=%b required 0", seen_done);
    end
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    tick(); tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_start_same: got busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    logic       done_e;
    logic [1:0] ei;
    for (int k = 0; k < 4; k++) fault_tbl[k] = 3'b000;
    start = 1'b1;
    tick();
    for (int t = 0; t <= 81; t++) begin
      done_e = (t == 40) || (t == 81);
      ei = (t < 40) ? 2'(t / 10) : (done_e ? 2'd0 : 2'((t - 41) / 10));
      n_cmp++;
      if ({busy, done, a, b} !== {~done_e, done_e, (done_e ? 1'b0 : ei[0]), (done_e ? 1'b0 : ei[1])}) begin
        n_bad++;
        $display("FAIL b2b t=%0d: got busy/done/a/b=%b required %b", t, {busy, done, a, b},
                 {~done_e, done_e, (done_e ? 1'b0 : ei[0]), (done_e ? 1'b0 : ei[1])});
      end
      if (t < 81) tick();
    end
    n_cmp++;
    if (result !== 12'h7B0 || mismatch_cnt !== 3'd0 || pass !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_score: got res=%h mis=%0d pass=%b required 7b0 0 1", result, mismatch_cnt, pass);
    end
    start = 1'b0;
    tick();
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_hold: got done=%b busy=%b pass=%b required 1 0 1", done, busy, pass);
    end
  endtask

  task automatic test_short_hold();
    int         exp_mis;
    logic [1:0] ei;
    exp_mis = 0;
    for (int k = 0; k < 4; k++)
      if (gold_y(2'(k)) != y_h) exp_mis++;
    start_h = 1'b1;
    tick();
    start_h = 1'b0;
    for (int t = 0; t < 8; t++) begin
      ei = 2'(t / 2);
      n_cmp++;
      if ({busy_h, done_h, vec_idx_h, a_h, b_h} !== {1'b1, 1'b0, ei, ei[0], ei[1]}) begin
        n_bad++;
        $display("FAIL short_drive t=%0d: got %b required %b", t,
                 {busy_h, done_h, vec_idx_h, a_h, b_h}, {1'b1, 1'b0, ei, ei[0], ei[1]});
      end
      tick();
    end
    n_cmp++;
    if (done_h !== 1'b1 || busy_h !== 1'b0 || result_h !== 12'h000 ||
        mismatch_cnt_h !== 3'(exp_mis) || pass_h !== 1'b0) begin
      n_bad++;
      $display("FAIL short_done: got done=%b busy=%b res=%h mis=%0d pass=%b required 1 0 000 %0d 0",
               done_h, busy_h, result_h, mismatch_cnt_h, pass_h, exp_mis);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    y_h = 3'b000;
    for (int k = 0; k < 4; k++) fault_tbl[k] = 3'b000;
    test_reset();
    test_clean_sweep();
    test_xnor();
    test_random_faults();
    test_start_ignored();
    test_rst_mid();
    test_back_to_back();
    test_short_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
